sram_like_axi_bridge: RTL
=========================

// Module: sram_like_axi_bridge
// PURPOSE
//  Converts the CPU core's two sram-like ports (instruction and data) into one AXI3 master.
//  Sits directly downstream of the core top and upstream of the AXI crossbar/RAM.
//  Supports one read and one write in flight at a time.
//  Data-port reads take priority over instruction reads. Read/write ordering is preserved conservatively.
// PARAMETERS
//  ID_INST   0  ARID used for instruction reads
//  ID_DATA   1  ARID/AWID/WID used for data accesses
// PORTS
//  clk                 in   1   clock; all state changes on posedge
//  reset               in   1   synchronous, active-high
//  inst_sram_req       in   1   inst request valid; held until addr_ok
//  inst_sram_wr        in   1   ignored; inst port is read-only
//  inst_sram_size      in   2   0=byte 1=half 2=word
//  inst_sram_wstrb     in   4   ignored
//  inst_sram_addr      in   32  physical address
//  inst_sram_wdata     in   32  ignored
//  inst_sram_addr_ok   out  1   request accepted this cycle
//  inst_sram_data_ok   out  1   read data valid this cycle
//  inst_sram_rdata     out  32  read data, valid only with data_ok
//  data_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  data request; wr=1 is a store
//  data_sram_{addr_ok,data_ok,rdata}         out 1/1/32         as on the inst port; data_ok also ends a store
//  arid/araddr/arsize/arvalid  out  4/32/3/1   AR channel; arready in 1
//  arlen=0 arburst=1 arlock=0 arcache=0 arprot=0 (also on AW)  out  constant ties
//  rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1
//  awid/awaddr/awsize/awvalid  out  4/32/3/1; awready in 1
//  wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
//  bid/bresp/bvalid  in  4/2/1; bready out 1
// BEHAVIOUR
//  Reset
//   - Both FSMs go IDLE.
//   - All *valid, rready, bready, addr_ok and data_ok are 0.
//   - Address/data registers are cleared to 0.
//   - Reset mid-transaction abandons the transaction; no data_ok is ever issued for it.
//  Read FSM: R_IDLE -> R_AR -> R_R -> R_IDLE
//   - Accept in R_IDLE when a read req is present and the write FSM is W_IDLE.
//   - Accept asserts the port's addr_ok combinationally in the same cycle and latches addr, size and id.
//   - Arbitration: data read beats inst read. The losing port sees addr_ok=0 and keeps req high.
//   - R_AR: arvalid=1 with registered araddr, arsize={1'b0,size}, arid. Move to R_R on arready.
//   - R_R: rready=1. On rvalid, pulse data_ok for the port selected by rid (ID_INST/ID_DATA).
//     rdata is passed through combinationally. Return to R_IDLE.
//   - Minimum latency: addr_ok at T, AR handshake at T+1, data_ok at T+2 when rvalid arrives at T+2.
//  Write FSM: W_IDLE -> W_AW -> W_B -> W_IDLE
//   - Accept a data write in W_IDLE when the read FSM is R_IDLE, or is reading for the inst port.
//   - Accept asserts data_addr_ok and latches addr, size, wstrb and wdata.
//   - W_AW: awvalid and wvalid both rise together. Each drops independently after its own handshake.
//     Move to W_B once both handshakes are done; they may occur in the same cycle.
//   - wlast=1 always. wstrb is the CPU strobe unmodified.
//   - W_B: bready=1. On bvalid, pulse data_ok for one cycle; data_rdata is don't-care. Return to W_IDLE.
//  Ordering rules
//   - No read is accepted while the write FSM is not W_IDLE (read-after-write safety).
//   - No data write is accepted while a data read is in flight.
//  Simultaneous events
//   - If a data write and an inst read both become acceptable in one cycle, both are accepted.
//   - Only one data_ok per port per cycle is guaranteed by construction (one outstanding access per port).
//  rresp and bresp are ignored. No error reporting.
// STRUCTURE
//  - Shared header mycpu_axi_defs.vh holds:
//    - `define state encodings R_IDLE/R_AR/R_R and W_IDLE/W_AW/W_B
//    - AXI constant ties (LEN, BURST_INCR, CACHE, PROT)
//    - ID_INST and ID_DATA defaults
//  - Flat module; no sub-module is warranted.
//  - Estimated size: ~200 lines.
// TESTING
//  1. Inst read 0xbfc00000 with arready=1 immediately and rvalid at T+2 (rid=0, rdata=0x24080001)
//     -> inst_addr_ok at T; arvalid=1 at T+1 only; inst_data_ok=1 with rdata=0x24080001 at T+2.
//  2. Inst and data reads raised in the same cycle
//     -> data accepted first (arid=1). inst_addr_ok stays 0 until the cycle after the data rvalid;
//        then the inst read issues with arid=0.
//  3. Data store addr 0x1faf0000, wdata 0xdeadbeef, wstrb 0xF; wready=1 at once, awready 2 cycles late
//     -> wvalid drops after 1 cycle; awvalid is held 3 cycles; data_ok in the bvalid cycle.
//  4. Data store outstanding (bvalid withheld), then a data load is raised
//     -> data_addr_ok=0 until the bvalid cycle; the load issues afterwards.
//  5. Byte store size=0 to 0x80000003 with wstrb 0x8
//     -> awsize=3'b000, awaddr=0x80000003, wstrb=0x8, wlast=1.
//  6. reset pulsed while in R_R and W_AW
//     -> next cycle arvalid/awvalid/wvalid/rready/bready=0; a later rvalid produces no data_ok.

Source files
------------

// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared encodings, AXI constant ties and request records for the sram-like to AXI3 bridge.
package sram_like_axi_bridge_pkg;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_B    = 2'd2;

    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'd0;
    localparam logic [2:0] AXI_PROT       = 3'd0;

    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  id;
    } rd_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_req_t;

    // CPU sizes never exceed a word, so the AXI size is the CPU size zero-extended.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Both sram-like CPU ports plus the AXI3 master bus; master = bridge view, slave = CPU/AXI side.
interface sram_like_axi_bridge_if;
    import sram_like_axi_bridge_pkg::*;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_like_axi_bridge.sv
// Bridges the CPU inst/data sram-like ports onto one AXI3 master, one read and one write in flight.
// Read: addr_ok T, AR T+1, data_ok with rvalid (>=T+2); write completes on bvalid; ports stall via addr_ok=0.
module sram_like_axi_bridge
    import sram_like_axi_bridge_pkg::*;
#(
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    sram_like_axi_bridge_if.master        bus
);

    logic [1:0] r_state;
    logic [1:0] w_state;
    rd_req_t    rd_q;
    rd_req_t    rd_nxt;
    wr_req_t    wr_q;
    logic       aw_done;
    logic       w_done;

    logic data_rd_req;
    logic data_wr_req;
    logic rd_open;
    logic rd_acc_data;
    logic rd_acc_inst;
    logic wr_acc;
    logic r_fire;
    logic b_fire;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign data_rd_req = bus.data_sram_req & ~bus.data_sram_wr;
    assign data_wr_req = bus.data_sram_req &  bus.data_sram_wr;

    // Reads wait for the write side to drain so a load never overtakes an older store.
    assign rd_open     = ~reset & (r_state == R_IDLE) & (w_state == W_IDLE);
    assign rd_acc_data = rd_open & data_rd_req;
    assign rd_acc_inst = rd_open & bus.inst_sram_req & ~data_rd_req;

    // A store may overlap an instruction fetch, never a data load.
    assign wr_acc = ~reset & (w_state == W_IDLE) & data_wr_req
                  & ((r_state == R_IDLE) | (rd_q.id == ID_INST));

    assign bus.inst_sram_addr_ok = rd_acc_inst;
    assign bus.data_sram_addr_ok = rd_acc_data | wr_acc;

    always_comb begin
        rd_nxt = '0;
        if (rd_acc_data) begin
            rd_nxt.addr = bus.data_sram_addr;
            rd_nxt.size = bus.data_sram_size;
            rd_nxt.id   = ID_DATA;
        end else begin
            rd_nxt.addr = bus.inst_sram_addr;
            rd_nxt.size = bus.inst_sram_size;
            rd_nxt.id   = ID_INST;
        end
    end

    assign bus.arid    = rd_q.id;
    assign bus.araddr  = rd_q.addr;
    assign bus.arsize  = axi_size(rd_q.size);
    assign bus.arlen   = AXI_LEN;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = AXI_LOCK;
    assign bus.arcache = AXI_CACHE;
    assign bus.arprot  = AXI_PROT;
    assign bus.arvalid = (r_state == R_AR);
    assign bus.rready  = (r_state == R_R);

    assign r_fire = bus.rready & bus.rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            rd_q    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_acc_data | rd_acc_inst) begin
                        r_state <= R_AR;
                        rd_q    <= rd_nxt;
                    end
                end
                R_AR: begin
                    if (bus.arready) begin
                        r_state <= R_R;
                    end
                end
                R_R: begin
                    if (bus.rvalid) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.awid    = ID_DATA;
    assign bus.awaddr  = wr_q.addr;
    assign bus.awsize  = axi_size(wr_q.size);
    assign bus.awlen   = AXI_LEN;
    assign bus.awburst = AXI_BURST_INCR;
    assign bus.awlock  = AXI_LOCK;
    assign bus.awcache = AXI_CACHE;
    assign bus.awprot  = AXI_PROT;
    assign bus.awvalid = (w_state == W_AW) & ~aw_done;

    assign bus.wid    = ID_DATA;
    assign bus.wdata  = wr_q.data;
    assign bus.wstrb  = wr_q.strb;
    assign bus.wlast  = 1'b1;
    assign bus.wvalid = (w_state == W_AW) & ~w_done;
    assign bus.bready = (w_state == W_B);

    assign aw_hs  = bus.awvalid & bus.awready;
    assign w_hs   = bus.wvalid & bus.wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;
    assign b_fire = bus.bready & bus.bvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            wr_q    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (wr_acc) begin
                        w_state   <= W_AW;
                        wr_q.addr <= bus.data_sram_addr;
                        wr_q.size <= bus.data_sram_size;
                        wr_q.strb <= bus.data_sram_wstrb;
                        wr_q.data <= bus.data_sram_wdata;
                    end
                end
                W_AW: begin
                    // AW and W complete independently; leave only when both are done.
                    if (aw_fin & w_fin) begin
                        w_state <= W_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                W_B: begin
                    if (bus.bvalid) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign bus.inst_sram_data_ok = ~reset & r_fire & (bus.rid == ID_INST);
    assign bus.data_sram_data_ok = ~reset & ((r_fire & (bus.rid == ID_DATA)) | b_fire);
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.data_sram_rdata   = bus.rdata;

    logic unused_ok;
    assign unused_ok = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                         bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule
